// File: rtl/i2c_mem_arbiter.sv
// i2c_mem_arbiter
//
// Shares the single-port byte memory behind the I2C slave between two requesters:
// port 0 (I2C slave engine) and port 1 (local/APB side). One access is in flight at a time.
//
// Ports
//   clk, rst            : clock (rising edge) and asynchronous active-high reset
//   reqN/weN/lockN      : request, 1 = write / 0 = read, keep ownership across requests
//   addrN/wdataN        : access address and write data, held stable until gntN
//   gntN                : one-cycle pulse, access issued to memory this cycle
//   rvalidN/rdataN      : one-cycle read-data strobe and read data (rdataN holds its value)
//   mem_ce/rden/wren    : memory strobes
//   mem_addr/mem_wdata  : memory address and write data
//   mem_rdata           : synchronous memory read data, valid the cycle after mem_rden
//
// Timing: IDLE samples requests; ISSUE drives the memory and gnt; RDATA captures read
// data, which is presented with rvalid one cycle later. Every output is registered.

module i2c_mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic              mem_ce,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdata
    } state_e;

    // Reset is asserted asynchronously but released on a clock edge so that no
    // flop leaves reset in a different cycle from its neighbours.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    // State and registered outputs
    state_e              state_q, state_d;
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic                last_owner_q, last_owner_d;
    logic                lock_valid_q, lock_valid_d;
    logic                lock_owner_q, lock_owner_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic                mem_ce_q, mem_ce_d;
    logic                mem_rden_q, mem_rden_d;
    logic                mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    // Arbitration
    logic [1:0]          req;
    logic [1:0]          lock_in;
    logic                lock_held;
    logic [1:0]          cand;
    logic                grant_any;
    logic                winner;
    logic                sel_we;
    logic                sel_lock;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign req     = {req1, req0};
    assign lock_in = {lock1, lock0};

    always_comb begin
        // A lock only survives while its owner keeps lockX high; dropping it
        // releases the lock before this cycle's arbitration.
        lock_held = lock_valid_q && lock_in[lock_owner_q];
        cand      = req;
        if (lock_held) begin
            cand = lock_owner_q ? (req & 2'b10) : (req & 2'b01);
        end
        grant_any = |cand;
        // On a tie the port that did not own the memory last time wins.
        winner    = (cand == 2'b11) ? ~last_owner_q : cand[1];
        sel_we    = winner ? we1    : we0;
        sel_lock  = winner ? lock1  : lock0;
        sel_addr  = winner ? addr1  : addr0;
        sel_wdata = winner ? wdata1 : wdata0;
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        we_d         = we_q;
        last_owner_d = last_owner_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        gnt_d        = 2'b00;
        rvalid_d     = 2'b00;
        mem_ce_d     = 1'b0;
        mem_rden_d   = 1'b0;
        mem_wren_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (!lock_held) begin
                    lock_valid_d = 1'b0;
                end
                if (grant_any) begin
                    // Outputs are registered, so the ISSUE-cycle strobes are
                    // loaded here from the winning port.
                    state_d        = StIssue;
                    win_d          = winner;
                    we_d           = sel_we;
                    last_owner_d   = winner;
                    lock_valid_d   = sel_lock;
                    lock_owner_d   = winner;
                    gnt_d[winner]  = 1'b1;
                    mem_ce_d       = 1'b1;
                    mem_wren_d     = sel_we;
                    mem_rden_d     = ~sel_we;
                    mem_addr_d     = sel_addr;
                    mem_wdata_d    = sel_wdata;
                end
            end
            StIssue: begin
                state_d = we_q ? StIdle : StRdata;
            end
            StRdata: begin
                rvalid_d[win_q] = 1'b1;
                if (win_q) begin
                    rdata1_d = mem_rdata;
                end else begin
                    rdata0_d = mem_rdata;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q      <= StIdle;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            last_owner_q <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            gnt_q        <= 2'b00;
            rvalid_q     <= 2'b00;
            mem_ce_q     <= 1'b0;
            mem_rden_q   <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            we_q         <= we_d;
            last_owner_q <= last_owner_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            mem_ce_q     <= mem_ce_d;
            mem_rden_q   <= mem_rden_d;
            mem_wren_q   <= mem_wren_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign gnt0      = gnt_q[0];
    assign gnt1      = gnt_q[1];
    assign rvalid0   = rvalid_q[0];
    assign rvalid1   = rvalid_q[1];
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_ce    = mem_ce_q;
    assign mem_rden  = mem_rden_q;
    assign mem_wren  = mem_wren_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Self-checking bench for i2c_mem_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level model of the arbitration and memory contents.

module tb_i2c_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0, we0, lock0, gnt0, rvalid0;
    logic [7:0] addr0, wdata0, rdata0;
    logic       req1, we1, lock1, gnt1, rvalid1;
    logic [7:0] addr1, wdata1, rdata1;
    logic       mem_ce, mem_rden, mem_wren;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    // Synchronous byte memory: read data appears the cycle after rden.
    always @(posedge clk) begin
        if (mem_ce && mem_rden) mem_rdata <= mem[mem_addr];
        if (mem_ce && mem_wren) mem[mem_addr] = mem_wdata;
    end

    i2c_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_ce(mem_ce), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_ce, mem_rden, mem_wren} !== 7'b0 ||
            mem_addr !== 8'h00 || mem_wdata !== 8'h00 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: strobes=%b addr=%h wdata=%h rdata0=%h rdata1=%h, want all 0",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_ce, mem_rden, mem_wren},
                     mem_addr, mem_wdata, rdata0, rdata1);
        end
        // Load rdata0 with a non-zero value first so its reset is observable.
        mem[8'h05] = 8'h5A;
        req0 = 1; we0 = 0; addr0 = 8'h05;
        tick(); req0 = 0;
        tick(); tick();
        n_cmp++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'h5A) begin
            n_err++;
            $display("FAIL reset_preload_read: rvalid0=%b rdata0=%h, want 1 5a", rvalid0, rdata0);
        end
        // Second read, reset arrives while it is in the data-capture cycle.
        tick();
        req0 = 1; addr0 = 8'h05;
        tick(); req0 = 0;
        tick();
        rst = 1;
        bad = 0;
        repeat (3) begin
            tick();
            if (gnt0 || gnt1 || rvalid0 || rvalid1 || mem_ce) bad++;
        end
        rst = 0;
        repeat (6) begin
            tick();
            if (gnt0 || gnt1 || rvalid0 || rvalid1 || mem_ce || mem_rden || mem_wren) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_midread_strobes: %0d cycles with strobes high, want 0", bad);
        end
        n_cmp++;
        if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_midread_rdata: rdata0=%h rdata1=%h, want 00 00", rdata0, rdata1);
        end
        // First tie after reset goes to port 0.
        req0 = 1; req1 = 1; addr0 = 8'h01; addr1 = 8'h02;
        tick();
        n_cmp++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_tie: gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_single_write_read();
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
        tick();
        n_cmp++;
        if (!(gnt0 === 1 && gnt1 === 0 && mem_ce === 1 && mem_wren === 1 && mem_rden === 0 &&
              mem_addr === 8'h10 && mem_wdata === 8'hA5)) begin
            n_err++;
            $display("FAIL single_write_issue: gnt0=%b ce=%b wren=%b rden=%b addr=%h wdata=%h, want 1 1 1 0 10 a5",
                     gnt0, mem_ce, mem_wren, mem_rden, mem_addr, mem_wdata);
        end
        req0 = 0;
        tick();
        n_cmp++;
        if (gnt0 !== 1'b0 || mem_ce !== 1'b0) begin
            n_err++;
            $display("FAIL single_write_pulse: gnt0=%b mem_ce=%b, want 0 0", gnt0, mem_ce);
        end
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        n_cmp++;
        if (gnt0 !== 1'b1 || mem_rden !== 1'b1 || mem_wren !== 1'b0 || mem_addr !== 8'h10) begin
            n_err++;
            $display("FAIL single_read_issue: gnt0=%b rden=%b wren=%b addr=%h, want 1 1 0 10",
                     gnt0, mem_rden, mem_wren, mem_addr);
        end
        req0 = 0;
        tick();
        n_cmp++;
        if (rvalid0 !== 1'b0) begin
            n_err++;
            $display("FAIL single_read_early: rvalid0=%b one cycle after gnt, want 0", rvalid0);
        end
        tick();
        n_cmp++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5) begin
            n_err++;
            $display("FAIL single_read_data: rvalid0=%b rdata0=%h, want 1 a5", rvalid0, rdata0);
        end
        tick();
        n_cmp++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'hA5) begin
            n_err++;
            $display("FAIL single_read_hold: rvalid0=%b rdata0=%h, want 0 a5", rvalid0, rdata0);
        end
    endtask

    task automatic test_round_robin();
        int g [4];
        int ng, nv0, nv1;
        do_reset();
        mem[8'h01] = 8'h11;
        mem[8'h02] = 8'h22;
        ng = 0; nv0 = 0; nv1 = 0;
        req0 = 1; we0 = 0; addr0 = 8'h01;
        req1 = 1; we1 = 0; addr1 = 8'h02;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rvalid0) begin
                nv0++;
                n_cmp++;
                if (rdata0 !== 8'h11) begin
                    n_err++;
                    $display("FAIL rr_rdata0: got %h, want 11", rdata0);
                end
            end
            if (rvalid1) begin
                nv1++;
                n_cmp++;
                if (rdata1 !== 8'h22) begin
                    n_err++;
                    $display("FAIL rr_rdata1: got %h, want 22", rdata1);
                end
            end
            if ((gnt0 || gnt1) && ng < 4) begin
                g[ng] = gnt1 ? 1 : 0;
                ng++;
                if (ng == 4) begin
                    req0 = 0; req1 = 0;
                end
            end
        end
        n_cmp++;
        if (ng != 4 || g[0] != 0 || g[1] != 1 || g[2] != 0 || g[3] != 1) begin
            n_err++;
            $display("FAIL rr_order: %0d grants %0d%0d%0d%0d, want 4 grants 0101",
                     ng, g[0], g[1], g[2], g[3]);
        end
        n_cmp++;
        if (nv0 != 2 || nv1 != 2) begin
            n_err++;
            $display("FAIL rr_rvalid_count: rvalid0=%0d rvalid1=%0d, want 2 2", nv0, nv1);
        end
    endtask

    task automatic test_lock_burst();
        int k, early, done;
        logic [7:0] got;
        do_reset();
        mem[8'h20] = 8'h00;
        k = 0; early = 0; done = 0; got = 8'h00;
        req0 = 1; we0 = 1; lock0 = 1; addr0 = 8'h20; wdata0 = 8'h80;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (!done) begin
                if (gnt1) begin
                    if (k < 4) early++;
                    req1 = 0;
                end
                if (gnt0) begin
                    k++;
                    if (k == 1) begin
                        req1 = 1; we1 = 0; addr1 = 8'h20;
                    end
                    if (k < 4) begin
                        addr0 = 8'h20 + 8'(k);
                        wdata0 = 8'h80 + 8'(k);
                    end else begin
                        req0 = 0; lock0 = 0;
                    end
                end
                if (rvalid1) begin
                    got = rdata1;
                    done = 1;
                end
            end
        end
        n_cmp++;
        if (early != 0 || k != 4) begin
            n_err++;
            $display("FAIL lock_no_interleave: gnt1 during burst=%0d burst grants=%0d, want 0 4", early, k);
        end
        n_cmp++;
        if (done != 1 || got !== 8'h80) begin
            n_err++;
            $display("FAIL lock_release_read: rvalid1 seen=%0d rdata1=%h, want 1 80", done, got);
        end
        n_cmp++;
        if (mem[8'h23] !== 8'h83) begin
            n_err++;
            $display("FAIL lock_last_write: mem[23]=%h, want 83", mem[8'h23]);
        end
    endtask

    task automatic test_write_read_order();
        int both, got;
        logic [7:0] d;
        mem[8'h40] = 8'hC3;
        both = 0; got = 0; d = 8'h00;
        req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 8'h3C;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_wren && mem_rden) both++;
            if (gnt1) begin
                req1 = 0;
                req0 = 1; we0 = 0; addr0 = 8'h40;
            end
            if (gnt0) req0 = 0;
            if (rvalid0) begin
                got++;
                d = rdata0;
            end
        end
        n_cmp++;
        if (got != 1 || d !== 8'h3C) begin
            n_err++;
            $display("FAIL order_read_new_data: rvalid0 count=%0d rdata0=%h, want 1 3c", got, d);
        end
        n_cmp++;
        if (both != 0) begin
            n_err++;
            $display("FAIL order_wren_rden_exclusive: %0d cycles both high, want 0", both);
        end
    endtask

    task automatic test_idle_withdraw();
        int g0, g1, ce, rv;
        g0 = 0; g1 = 0; ce = 0; rv = 0;
        req0 = 1; we0 = 0; addr0 = 8'h05;
        tick();
        req0 = 0;
        req1 = 1; we1 = 0; addr1 = 8'h30;
        tick();
        req1 = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (gnt0) g0++;
            if (gnt1) g1++;
            if (mem_ce) ce++;
            if (rvalid0) rv++;
        end
        n_cmp++;
        if (g1 != 0 || g0 != 0 || ce != 0) begin
            n_err++;
            $display("FAIL withdraw_no_access: gnt0=%0d gnt1=%0d mem_ce=%0d, want 0 0 0", g0, g1, ce);
        end
        n_cmp++;
        if (rv != 1) begin
            n_err++;
            $display("FAIL withdraw_port0_read: rvalid0 count=%0d, want 1", rv);
        end
    endtask

    task automatic test_random();
        logic [7:0] shadow [256];
        bit         pend [2];
        bit         p_we [2];
        bit         cur_lock [2];
        logic [7:0] p_addr [2];
        logic [7:0] p_wdata [2];
        bit         e_gnt [2][8];
        bit         e_rv [2][8];
        logic [7:0] e_rd [2][8];
        logic [7:0] e_rdata [2];
        int         busy, last_owner, lock_owner, w, s;

        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; p_we[p] = 0; cur_lock[p] = 0; p_addr[p] = 0; p_wdata[p] = 0;
            e_rdata[p] = 8'h00;
            for (int j = 0; j < 8; j++) begin
                e_gnt[p][j] = 0; e_rv[p][j] = 0; e_rd[p][j] = 8'h00;
            end
        end
        busy = 0; last_owner = 1; lock_owner = -1;

        for (int t = 0; t < 800; t++) begin
            s = t % 8;
            n_cmp++;
            if (gnt0 !== e_gnt[0][s] || gnt1 !== e_gnt[1][s]) begin
                n_err++;
                $display("FAIL rand_gnt t=%0d: gnt0=%b gnt1=%b, want %b %b",
                         t, gnt0, gnt1, e_gnt[0][s], e_gnt[1][s]);
            end
            for (int p = 0; p < 2; p++) if (e_rv[p][s]) e_rdata[p] = e_rd[p][s];
            n_cmp++;
            if (rvalid0 !== e_rv[0][s] || rvalid1 !== e_rv[1][s] ||
                rdata0 !== e_rdata[0] || rdata1 !== e_rdata[1]) begin
                n_err++;
                $display("FAIL rand_rdata t=%0d: rvalid=%b%b rdata0=%h rdata1=%h, want %b%b %h %h",
                         t, rvalid1, rvalid0, rdata0, rdata1,
                         e_rv[1][s], e_rv[0][s], e_rdata[0], e_rdata[1]);
            end
            for (int p = 0; p < 2; p++) begin
                if (e_gnt[p][s]) pend[p] = 0;
                e_gnt[p][s] = 0;
                e_rv[p][s] = 0;
            end

            // Requesters: hold a pending request, occasionally withdraw it,
            // otherwise maybe start a new one.
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) begin
                    if ($urandom_range(15, 0) == 0) pend[p] = 0;
                end else if ($urandom_range(1, 0) == 1) begin
                    pend[p]     = 1;
                    p_we[p]     = ($urandom_range(1, 0) == 1);
                    cur_lock[p] = ($urandom_range(2, 0) == 0);
                    p_addr[p]   = 8'h60 + 8'($urandom_range(7, 0));
                    p_wdata[p]  = 8'($urandom_range(255, 0));
                end else begin
                    cur_lock[p] = ($urandom_range(3, 0) == 0);
                end
            end
            req0 = pend[0]; we0 = p_we[0]; lock0 = cur_lock[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
            req1 = pend[1]; we1 = p_we[1]; lock1 = cur_lock[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];

            // Reference: decide this cycle's winner when the arbiter is free.
            if (busy == 0) begin
                if (lock_owner >= 0 && !cur_lock[lock_owner]) lock_owner = -1;
                w = -1;
                if (lock_owner >= 0) begin
                    if (pend[lock_owner]) w = lock_owner;
                end else if (pend[0] && pend[1]) begin
                    w = 1 - last_owner;
                end else if (pend[0]) begin
                    w = 0;
                end else if (pend[1]) begin
                    w = 1;
                end
                if (w >= 0) begin
                    e_gnt[w][(t + 1) % 8] = 1;
                    last_owner = w;
                    lock_owner = cur_lock[w] ? w : -1;
                    if (p_we[w]) begin
                        shadow[p_addr[w]] = p_wdata[w];
                        busy = 1;
                    end else begin
                        e_rv[w][(t + 3) % 8] = 1;
                        e_rd[w][(t + 3) % 8] = shadow[p_addr[w]];
                        busy = 2;
                    end
                end
            end else begin
                busy--;
            end
            tick();
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        idle_inputs();
        test_reset();
        test_single_write_read();
        test_round_robin();
        test_lock_burst();
        test_write_read_order();
        test_idle_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
